polyline_sequencer: RTL and testbench

Sequences the thick-line drawing circuit so a producer can stream polyline vertices instead of hand-driving each segment. Vertices are buffered in a small FIFO. Each new vertex forms a segment with the previous one, and the block issues that segment to the line circuit through a go/done handshake. It sits between the visualizer's waveform generator (producer) and the thick-line circuit, whose pixel/memory side it never touches.

---
 rtl/polyline_sequencer_pkg.sv | 31 +++
 rtl/polyline_sequencer_if.sv | 32 +++
 rtl/polyline_sequencer_vertex_fifo.sv | 81 ++++++++
 rtl/polyline_sequencer.sv | 152 +++++++++++++++
 tb/tb_polyline_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/polyline_sequencer_pkg.sv
// polyline_pkg: shared types and screen constants for the polyline sequencer.
// The sequencer state enum, the buffered vertex record and the default
// screen limits used for coordinate clipping (POLYLINE_CLIP_EN builds).
package polyline_pkg;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      GO     = 3'd2,
      SETTLE = 3'd3,
      WAIT   = 3'd4
   } seq_state_t;

   // One buffered vertex: 1 + 9 + 8 = 18 bits
   typedef struct packed {
      logic       first;
      logic [8:0] x;
      logic [7:0] y;
   } vertex_t;

   localparam int X_MAX_DEF = 319;
   localparam int Y_MAX_DEF = 239;

   // True when two points coincide, i.e. the segment between them is empty
   function automatic logic same_point(input logic [8:0] ax, input logic [7:0] ay,
                                       input logic [8:0] bx, input logic [7:0] by);
      return (ax == bx) && (ay == by);
   endfunction

endpackage

// File: rtl/polyline_sequencer_if.sv
// polyline_sequencer_if: producer vertex stream plus the go/done link to
// the thick-line circuit. slave = the sequencer, master = its environment.
interface polyline_sequencer_if;

   // producer side
   logic       pt_valid;
   logic       pt_ready;
   logic [8:0] pt_x;
   logic [7:0] pt_y;
   logic       pt_first;
   logic [8:0] thickness_in;

   // line circuit side
   logic       tlda_go;
   logic [8:0] tlda_x0;
   logic [8:0] tlda_x1;
   logic [7:0] tlda_y0;
   logic [7:0] tlda_y1;
   logic [8:0] tlda_thickness;
   logic       tlda_done;

   modport master (
      output pt_valid, pt_x, pt_y, pt_first, thickness_in, tlda_done,
      input  pt_ready, tlda_go, tlda_x0, tlda_x1, tlda_y0, tlda_y1, tlda_thickness
   );

   modport slave (
      input  pt_valid, pt_x, pt_y, pt_first, thickness_in, tlda_done,
      output pt_ready, tlda_go, tlda_x0, tlda_x1, tlda_y0, tlda_y1, tlda_thickness
   );

endinterface

// File: rtl/polyline_sequencer_vertex_fifo.sv
// vertex_fifo: synchronous vertex FIFO with registered full/empty flags and
// an occupancy output. The head entry is read combinationally so the
// sequencer can pop and latch it on the same clock edge.
module vertex_fifo
   import polyline_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  vertex_t                wr_data,
   output vertex_t                rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   vertex_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [LW-1:0]   level_reg;
   logic [LW-1:0]   level_next;
   logic            full_reg;
   logic            empty_reg;
   logic            do_push;
   logic            do_pop;

   // Requests are qualified by the registered flags, so a push while full
   // or a pop while empty is simply ignored.
   assign do_push = push && !full_reg;
   assign do_pop  = pop && !empty_reg;

   // Next occupancy: simultaneous push and pop leave it unchanged
   always_comb begin
      level_next = level_reg;
      case ({do_push, do_pop})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   // Storage write; contents need no reset because the flags guard reads
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers, occupancy and registered flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         level_reg <= level_next;
         full_reg  <= (level_next == LW'(DEPTH));
         empty_reg <= (level_next == '0);
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign full    = full_reg;
   assign empty   = empty_reg;
   assign level   = level_reg;

endmodule

// File: rtl/polyline_sequencer.sv
// polyline_sequencer: buffers streamed polyline vertices and issues one
// segment per consecutive vertex pair to the thick-line circuit via a
// go/done handshake. Vertices flagged first start a new polyline without
// drawing; zero-length segments are dropped.
// Optional feature macro: POLYLINE_CLIP_EN (saturate incoming coordinates
// to X_MAX/Y_MAX at the FIFO write port).
module polyline_sequencer
   import polyline_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int X_MAX      = X_MAX_DEF,
   parameter int Y_MAX      = Y_MAX_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   polyline_sequencer_if.slave         bus,
   output logic                        busy,
   output logic [15:0]                 seg_count,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

`ifdef POLYLINE_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   localparam logic [8:0] X_LIM = 9'(X_MAX);
   localparam logic [7:0] Y_LIM = 8'(Y_MAX);

   vertex_t     wr_vertex;
   vertex_t     fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        fifo_pop;

   seq_state_t  state_reg;
   vertex_t     cur_reg;
   logic [8:0]  prev_x_reg;
   logic [7:0]  prev_y_reg;
   logic        have_prev_reg;
   logic        go_reg;
   logic [8:0]  x0_reg;
   logic [8:0]  x1_reg;
   logic [7:0]  y0_reg;
   logic [7:0]  y1_reg;
   logic [8:0]  thickness_reg;
   logic [15:0] seg_count_reg;

   // Write-port formatting, with optional saturation so that degenerate
   // detection later compares the clipped coordinates.
   always_comb begin
      wr_vertex.first = bus.pt_first;
      wr_vertex.x     = (CLIP_EN && (bus.pt_x > X_LIM)) ? X_LIM : bus.pt_x;
      wr_vertex.y     = (CLIP_EN && (bus.pt_y > Y_LIM)) ? Y_LIM : bus.pt_y;
   end

   // The head is consumed only from IDLE, one vertex per segment decision
   assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

   vertex_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (bus.pt_valid),
      .pop     (fifo_pop),
      .wr_data (wr_vertex),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Segment sequencer with registered handshake and endpoint outputs.
   // tlda_go is set on the edge into GO and cleared on every other edge,
   // so it is high exactly while in GO. SETTLE exists because the line
   // circuit still shows done during the cycle it receives go.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cur_reg       <= '0;
         prev_x_reg    <= '0;
         prev_y_reg    <= '0;
         have_prev_reg <= 1'b0;
         go_reg        <= 1'b0;
         x0_reg        <= '0;
         x1_reg        <= '0;
         y0_reg        <= '0;
         y1_reg        <= '0;
         thickness_reg <= '0;
         seg_count_reg <= '0;
      end else begin
         go_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  cur_reg   <= fifo_head;
                  state_reg <= FETCH;
               end
            end
            FETCH: begin
               if (cur_reg.first || !have_prev_reg) begin
                  prev_x_reg    <= cur_reg.x;
                  prev_y_reg    <= cur_reg.y;
                  have_prev_reg <= 1'b1;
                  state_reg     <= IDLE;
               end else if (same_point(cur_reg.x, cur_reg.y, prev_x_reg, prev_y_reg)) begin
                  state_reg <= IDLE;
               end else begin
                  go_reg        <= 1'b1;
                  x0_reg        <= prev_x_reg;
                  y0_reg        <= prev_y_reg;
                  x1_reg        <= cur_reg.x;
                  y1_reg        <= cur_reg.y;
                  thickness_reg <= bus.thickness_in;
                  state_reg     <= GO;
               end
            end
            GO: begin
               state_reg <= SETTLE;
            end
            SETTLE: begin
               state_reg <= WAIT;
            end
            WAIT: begin
               if (bus.tlda_done) begin
                  prev_x_reg    <= cur_reg.x;
                  prev_y_reg    <= cur_reg.y;
                  seg_count_reg <= seg_count_reg + 16'd1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.pt_ready       = !fifo_full;
   assign bus.tlda_go        = go_reg;
   assign bus.tlda_x0        = x0_reg;
   assign bus.tlda_y0        = y0_reg;
   assign bus.tlda_x1        = x1_reg;
   assign bus.tlda_y1        = y1_reg;
   assign bus.tlda_thickness = thickness_reg;

   assign busy      = (state_reg != IDLE) || !fifo_empty;
   assign seg_count = seg_count_reg;

endmodule

// File: tb/tb_polyline_sequencer.sv
// tb_polyline_sequencer: randomized and directed vertex streams against a
// segment-list reference model; a small line-circuit model answers go with
// done after a (random or fixed) delay, or can stall / answer instantly.
module tb_polyline_sequencer;
   import polyline_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        busy;
   logic [15:0] seg_count;
   logic [3:0]  fifo_level;

   always #5 clk = ~clk;

   polyline_sequencer_if bus();

   polyline_sequencer #(
      .FIFO_DEPTH (8),
      .X_MAX      (X_MAX_DEF),
      .Y_MAX      (Y_MAX_DEF)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .seg_count  (seg_count),
      .fifo_level (fifo_level)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model: expected segment list ----------------
   typedef struct {
      int x0;
      int y0;
      int x1;
      int y1;
   } seg_t;

   seg_t        exp_q[$];
   bit          m_have_prev = 1'b0;
   int          m_px = 0;
   int          m_py = 0;
   int          m_seg_total = 0;
   logic [8:0]  thick = 9'd3;

   function automatic void model_push(input int x, input int y, input bit first);
`ifdef POLYLINE_CLIP_EN
      if (x > X_MAX_DEF) x = X_MAX_DEF;
      if (y > Y_MAX_DEF) y = Y_MAX_DEF;
`endif
      if (first || !m_have_prev) begin
         m_have_prev = 1'b1;
         m_px = x;
         m_py = y;
      end else if (x != m_px || y != m_py) begin
         exp_q.push_back('{m_px, m_py, x, y});
         m_seg_total++;
         m_px = x;
         m_py = y;
      end
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_have_prev = 1'b0;
      m_seg_total = 0;
   endfunction

   // ---------------- line circuit model ----------------
   bit stall = 1'b0;
   bit always_done = 1'b0;
   int fixed_delay = 7;

   initial begin
      int line_cnt;
      line_cnt = 0;
      bus.tlda_done = 1'b1;
      forever begin
         @(negedge clk);
         if (reset) begin
            line_cnt = 0;
            bus.tlda_done = 1'b1;
         end else if (stall) begin
            line_cnt = 0;
            bus.tlda_done = 1'b0;
         end else if (always_done) begin
            bus.tlda_done = 1'b1;
         end else if (bus.tlda_go) begin
            line_cnt = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 9));
            bus.tlda_done = 1'b0;
         end else if (line_cnt > 0) begin
            line_cnt--;
            bus.tlda_done = (line_cnt == 0);
         end else begin
            bus.tlda_done = 1'b1;
         end
      end
   end

   // ---------------- go / seg_count monitor ----------------
   int go_count = 0;
   int cycle = 0;

   initial begin
      bit   prev_go;
      int   last_go_cycle;
      logic [15:0] last_seg;
      seg_t s;
      prev_go = 1'b0;
      last_go_cycle = 0;
      last_seg = '0;
      forever begin
         @(negedge clk);
         cycle++;
         if (reset) begin
            prev_go = 1'b0;
            last_seg = '0;
            continue;
         end
         if (bus.tlda_go) begin
            go_count++;
            last_go_cycle = cycle;
            check("go_single_cycle", 32'(prev_go), 32'(0));
            check("go_expected", 32'(exp_q.size() > 0), 32'(1));
            if (exp_q.size() > 0) begin
               s = exp_q.pop_front();
               $display("go #%0d (%0d,%0d)-(%0d,%0d) th=%0d", go_count,
                        bus.tlda_x0, bus.tlda_y0, bus.tlda_x1, bus.tlda_y1, bus.tlda_thickness);
               check("seg_x0", 32'(bus.tlda_x0), 32'(s.x0));
               check("seg_y0", 32'(bus.tlda_y0), 32'(s.y0));
               check("seg_x1", 32'(bus.tlda_x1), 32'(s.x1));
               check("seg_y1", 32'(bus.tlda_y1), 32'(s.y1));
               check("seg_thickness", 32'(bus.tlda_thickness), 32'(thick));
            end
         end
         if (seg_count != last_seg) begin
            check("seg_count_step", 32'(seg_count), 32'(16'(last_seg + 16'd1)));
            check("settle_gap", 32'((cycle - last_go_cycle) >= 3), 32'(1));
            last_seg = seg_count;
         end
         prev_go = bus.tlda_go;
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic push_vertex(input logic [8:0] x, input logic [7:0] y, input logic first);
      int n;
      n = 0;
      bus.pt_x = x;
      bus.pt_y = y;
      bus.pt_first = first;
      bus.pt_valid = 1'b1;
      while (!bus.pt_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("push_accept", 32'(bus.pt_ready), 32'(1));
      if (bus.pt_ready) begin
         @(posedge clk);
         model_push(int'(x), int'(y), first);
         @(negedge clk);
      end
      bus.pt_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_drained"}, 32'(n < 5000), 32'(1));
      repeat (2) @(negedge clk);
      check({tag, "_seg_count"}, 32'(seg_count), 32'(m_seg_total[15:0]));
      check({tag, "_busy"}, 32'(busy), 32'(0));
      check({tag, "_level"}, 32'(fifo_level), 32'(0));
   endtask

   task automatic random_phase(input int n);
      logic [8:0] x;
      logic [7:0] y;
      logic       first;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            x = 9'($urandom_range(0, 2));
            y = 8'($urandom_range(0, 2));
         end else begin
`ifdef POLYLINE_CLIP_EN
            x = 9'($urandom_range(0, 511));
            y = 8'($urandom_range(0, 255));
`else
            x = 9'($urandom_range(0, X_MAX_DEF));
            y = 8'($urandom_range(0, Y_MAX_DEF));
`endif
         end
         first = ($urandom_range(0, 5) == 0);
         push_vertex(x, y, first);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int go_before;
      bus.pt_valid = 1'b0;
      bus.pt_x = '0;
      bus.pt_y = '0;
      bus.pt_first = 1'b0;
      bus.thickness_in = thick;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_pt_ready", 32'(bus.pt_ready), 32'(1));
      check("rst_go", 32'(bus.tlda_go), 32'(0));
      check("rst_x0", 32'(bus.tlda_x0), 32'(0));
      check("rst_y0", 32'(bus.tlda_y0), 32'(0));
      check("rst_x1", 32'(bus.tlda_x1), 32'(0));
      check("rst_y1", 32'(bus.tlda_y1), 32'(0));
      check("rst_seg_count", 32'(seg_count), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_level", 32'(fifo_level), 32'(0));

      // basic two-segment polyline, done 7 cycles after go
      fixed_delay = 7;
      push_vertex(9'd10, 8'd20, 1'b1);
      push_vertex(9'd100, 8'd50, 1'b0);
      push_vertex(9'd100, 8'd200, 1'b0);
      check("basic_busy", 32'(busy), 32'(1));
      drain("basic");

      // degenerate segments and restarted polylines
      thick = 9'd5;
      bus.thickness_in = thick;
      push_vertex(9'd5, 8'd5, 1'b1);
      push_vertex(9'd5, 8'd5, 1'b0);
      push_vertex(9'd5, 8'd5, 1'b1);
      push_vertex(9'd9, 8'd9, 1'b0);
      drain("degenerate");

      // fill the FIFO while the line circuit is stalled
      stall = 1'b1;
      push_vertex(9'd10, 8'd5, 1'b1);
      for (int i = 1; i < 10; i++) begin
         push_vertex(9'(10 + i * 20), 8'(5 + i * 10), 1'b0);
      end
      repeat (2) @(negedge clk);
      check("fill_pt_ready", 32'(bus.pt_ready), 32'(0));
      check("fill_level", 32'(fifo_level), 32'(8));
      stall = 1'b0;
      n = 0;
      while (fifo_level == 4'd8 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("fill_release_pop", 32'(n < 200), 32'(1));
      check("fill_ready_after_pop", 32'(bus.pt_ready), 32'(1));
      drain("fill");

      // line circuit reports done constantly
      always_done = 1'b1;
      random_phase(40);
      drain("always_done");
      always_done = 1'b0;

      // random line-circuit latency
      fixed_delay = 0;
      for (int r = 0; r < 3; r++) begin
         thick = 9'($urandom_range(0, 511));
         bus.thickness_in = thick;
         random_phase(50);
         drain("random");
      end

      // out-of-range coordinates (clipped only when the feature is built)
      push_vertex(9'd400, 8'd250, 1'b1);
      push_vertex(9'd0, 8'd0, 1'b0);
      drain("clip");

      // reset while waiting on the line circuit with vertices queued
      stall = 1'b1;
      go_before = go_count;
      push_vertex(9'd20, 8'd20, 1'b1);
      push_vertex(9'd30, 8'd30, 1'b0);
      n = 0;
      while (go_count == go_before && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rstwait_go_seen", 32'(n < 200), 32'(1));
      repeat (3) @(negedge clk);
      push_vertex(9'd40, 8'd40, 1'b0);
      push_vertex(9'd50, 8'd50, 1'b0);
      push_vertex(9'd60, 8'd60, 1'b0);
      check("rstwait_level", 32'(fifo_level), 32'(3));
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rstwait_level_cleared", 32'(fifo_level), 32'(0));
      check("rstwait_go", 32'(bus.tlda_go), 32'(0));
      check("rstwait_seg_count", 32'(seg_count), 32'(0));
      check("rstwait_busy", 32'(busy), 32'(0));
      check("rstwait_pt_ready", 32'(bus.pt_ready), 32'(1));
      model_reset();
      stall = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      go_before = go_count;
      push_vertex(9'd70, 8'd70, 1'b0);
      repeat (20) @(negedge clk);
      check("rstwait_no_draw", 32'(go_count), 32'(go_before));
      check("rstwait_no_count", 32'(seg_count), 32'(0));
      push_vertex(9'd80, 8'd80, 1'b0);
      drain("after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
